// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control/status bundle between the multicycle FSM and the datapath
// master is the controller side; slave is the datapath (or bench) side.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic [1:0] PCSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ExtOp;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, IorD, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrcB,
           ALUOp, ExtOp, RegDst, MemtoReg, RegWrite, instr_done, illegal, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, IorD, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrcB,
           ALUOp, ExtOp, RegDst, MemtoReg, RegWrite, instr_done, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS main control FSM
// Only the state register is stateful; every datapath control is decoded from state/opcode/flags.
module multicycle_ctrl (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_ctrl_if.master    bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQEX   = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JEX     = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_e state_q, state_d, cur;
  logic   is_logic_imm, is_lui;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign is_lui       = (bus.opcode == OP_LUI);
  assign is_logic_imm = (bus.opcode == OP_ANDI) || (bus.opcode == OP_ORI);

  always_comb begin
    state_d        = S_FETCH;
    bus.mem_req    = 1'b0;
    bus.IorD       = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.PCSrc      = 2'b00;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ALUOp      = 2'b00;
    bus.ExtOp      = 2'b00;
    bus.RegDst     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;

    // Under reset decode as FETCH so an in-flight access cannot commit anything.
    cur = reset ? S_FETCH : state_q;

    case (cur)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
        state_d     = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        bus.ALUSrcB = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW:                       state_d = S_MEMADR;
          OP_R:                               state_d = S_RTYPEEX;
          OP_BEQ:                             state_d = S_BEQEX;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:   state_d = S_IMMEX;
          OP_J:                               state_d = S_JEX;
          default: begin
            state_d        = S_FETCH;
            bus.illegal    = 1'b1;
            bus.instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.mem_req = 1'b1;
        bus.IorD    = 1'b1;
        state_d     = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        bus.RegWrite   = 1'b1;
        bus.MemtoReg   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_MEMWR: begin
        bus.mem_req    = 1'b1;
        bus.IorD       = 1'b1;
        bus.MemWrite   = bus.mem_ready;
        bus.instr_done = bus.mem_ready;
        state_d        = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegWrite   = 1'b1;
        bus.RegDst     = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_BEQEX: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUOp      = 2'b01;
        bus.PCSrc      = 2'b01;
        bus.PCWrite    = bus.zero;
        bus.instr_done = 1'b1;
      end
      S_IMMEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.ExtOp   = is_lui ? 2'b10 : (is_logic_imm ? 2'b01 : 2'b00);
        bus.ALUOp   = (is_lui || is_logic_imm) ? 2'b11 : 2'b00;
        state_d     = S_IMMWB;
      end
      S_IMMWB: begin
        // ExtOp held so the extended immediate stays stable through the writeback cycle.
        bus.ExtOp      = is_lui ? 2'b10 : (is_logic_imm ? 2'b01 : 2'b00);
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_JEX: begin
        bus.PCSrc      = 2'b10;
        bus.PCWrite    = 1'b1;
        bus.instr_done = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    if (reset) begin
      bus.PCWrite = 1'b0;
      bus.IRWrite = 1'b0;
    end
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b000010;

  multicycle_ctrl_if bus ();
  multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus.master));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.mem_ready = 1'b1; bus.opcode = OP_LW; bus.zero = 1'b0;
    @(negedge clk);
    tests++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL rst_mem_req got %0b want 1", bus.mem_req); end
    tests++; if (bus.IorD !== 1'b0) begin fails++; $display("FAIL rst_iord got %0b want 0", bus.IorD); end
    tests++; if (bus.ALUSrcB !== 2'b01) begin fails++; $display("FAIL rst_alusrcb got %0b want 01", bus.ALUSrcB); end
    tests++; if (bus.PCWrite !== 1'b0 || bus.IRWrite !== 1'b0) begin fails++; $display("FAIL rst_pc_ir got %0b%0b want 00", bus.PCWrite, bus.IRWrite); end
    tick();
    @(negedge clk);
    tests++; if (bus.state !== 4'd0) begin fails++; $display("FAIL rst_state got %0d want 0", bus.state); end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if (bus.state !== 4'(i)) begin fails++; $display("FAIL rst_seq%0d got %0d want %0d", i, bus.state, i); end
      tick();
    end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    tests++; if (bus.state !== 4'd3 || bus.RegWrite !== 1'b0 || bus.mem_req !== 1'b1) begin
      fails++; $display("FAIL rst_memrd got st=%0d rw=%0b req=%0b want 3/0/1", bus.state, bus.RegWrite, bus.mem_req); end
    tick();
    reset = 1'b1; bus.mem_ready = 1'b1;
    @(negedge clk);
    tests++; if (bus.RegWrite !== 1'b0 || bus.MemWrite !== 1'b0 || bus.PCWrite !== 1'b0 || bus.mem_req !== 1'b1) begin
      fails++; $display("FAIL rst_midrd got rw=%0b mw=%0b pw=%0b req=%0b want 0/0/0/1", bus.RegWrite, bus.MemWrite, bus.PCWrite, bus.mem_req); end
    tick();
    reset = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);
    tests++; if (bus.state !== 4'd0 || bus.RegWrite !== 1'b0) begin fails++; $display("FAIL rst_after got st=%0d rw=%0b want 0/0", bus.state, bus.RegWrite); end
    tick();
  endtask

  task automatic test_lw();
    int exp_st[8] = '{0, 0, 0, 1, 2, 3, 3, 4};
    logic mr[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int irw = 0;
    bus.opcode = OP_LW;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = mr[i];
      @(negedge clk);
      irw += int'(bus.IRWrite);
      tests++; if (bus.state !== 4'(exp_st[i])) begin fails++; $display("FAIL lw_state%0d got %0d want %0d", i, bus.state, exp_st[i]); end
      tests++; if (bus.instr_done !== (exp_st[i] == 4)) begin fails++; $display("FAIL lw_done%0d got %0b want %0b", i, bus.instr_done, exp_st[i] == 4); end
      if (exp_st[i] == 4) begin
        tests++; if (bus.RegWrite !== 1'b1 || bus.MemtoReg !== 1'b1 || bus.RegDst !== 1'b0) begin
          fails++; $display("FAIL lw_wb got rw=%0b m2r=%0b rd=%0b want 1/1/0", bus.RegWrite, bus.MemtoReg, bus.RegDst); end
      end
      tick();
    end
    tests++; if (irw !== 1) begin fails++; $display("FAIL lw_irwrite_count got %0d want 1", irw); end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    tests++; if (bus.state !== 4'd0) begin fails++; $display("FAIL lw_end got %0d want 0", bus.state); end
    tick();
  endtask

  task automatic test_beq();
    logic zv[2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      bus.opcode = OP_BEQ; bus.zero = zv[k]; bus.mem_ready = 1'b1;
      @(negedge clk);
      tests++; if (bus.state !== 4'd0 || bus.IRWrite !== 1'b1) begin fails++; $display("FAIL beq%0d_fetch got st=%0d irw=%0b want 0/1", k, bus.state, bus.IRWrite); end
      tick();
      @(negedge clk);
      tests++; if (bus.state !== 4'd1 || bus.ALUSrcB !== 2'b11) begin fails++; $display("FAIL beq%0d_decode got st=%0d srcb=%0b want 1/11", k, bus.state, bus.ALUSrcB); end
      tick();
      @(negedge clk);
      tests++; if (bus.state !== 4'd8 || bus.PCWrite !== zv[k] || bus.PCSrc !== 2'b01 || bus.ALUOp !== 2'b01 || bus.instr_done !== 1'b1) begin
        fails++; $display("FAIL beq%0d_ex got st=%0d pw=%0b src=%0b op=%0b done=%0b want 8/%0b/01/01/1", k, bus.state, bus.PCWrite, bus.PCSrc, bus.ALUOp, bus.instr_done, zv[k]); end
      tick();
      bus.mem_ready = 1'b0;
      @(negedge clk);
      tests++; if (bus.state !== 4'd0) begin fails++; $display("FAIL beq%0d_end got %0d want 0", k, bus.state); end
      tick();
    end
    bus.zero = 1'b0;
  endtask

  task automatic test_imm();
    logic [5:0] ops[3] = '{OP_ORI, OP_LUI, OP_ADDI};
    logic [1:0] ext[3] = '{2'b01, 2'b10, 2'b00};
    logic [1:0] aop[3] = '{2'b11, 2'b11, 2'b00};
    for (int k = 0; k < 3; k++) begin
      bus.opcode = ops[k]; bus.mem_ready = 1'b1;
      tick();
      tick();
      @(negedge clk);
      tests++; if (bus.state !== 4'd9 || bus.ExtOp !== ext[k] || bus.ALUOp !== aop[k] || bus.ALUSrcA !== 1'b1 || bus.ALUSrcB !== 2'b10) begin
        fails++; $display("FAIL imm%0d_ex got st=%0d ext=%0b op=%0b a=%0b b=%0b want 9/%0b/%0b/1/10", k, bus.state, bus.ExtOp, bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, ext[k], aop[k]); end
      tick();
      @(negedge clk);
      tests++; if (bus.state !== 4'd10 || bus.ExtOp !== ext[k] || bus.RegWrite !== 1'b1 || bus.RegDst !== 1'b0 || bus.MemtoReg !== 1'b0 || bus.instr_done !== 1'b1) begin
        fails++; $display("FAIL imm%0d_wb got st=%0d ext=%0b rw=%0b rd=%0b m2r=%0b done=%0b want 10/%0b/1/0/0/1", k, bus.state, bus.ExtOp, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.instr_done, ext[k]); end
      tick();
      bus.mem_ready = 1'b0;
      @(negedge clk);
      tests++; if (bus.state !== 4'd0) begin fails++; $display("FAIL imm%0d_end got %0d want 0", k, bus.state); end
      tick();
    end
  endtask

  task automatic test_illegal();
    bus.opcode = 6'b111111; bus.mem_ready = 1'b1;
    @(negedge clk);
    tests++; if (bus.PCWrite !== 1'b1) begin fails++; $display("FAIL ill_fetch_pc got %0b want 1", bus.PCWrite); end
    tick();
    @(negedge clk);
    tests++; if (bus.state !== 4'd1 || bus.illegal !== 1'b1 || bus.instr_done !== 1'b1) begin
      fails++; $display("FAIL ill_decode got st=%0d ill=%0b done=%0b want 1/1/1", bus.state, bus.illegal, bus.instr_done); end
    tests++; if (bus.RegWrite !== 1'b0 || bus.MemWrite !== 1'b0 || bus.PCWrite !== 1'b0) begin
      fails++; $display("FAIL ill_writes got rw=%0b mw=%0b pw=%0b want 0/0/0", bus.RegWrite, bus.MemWrite, bus.PCWrite); end
    tick();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    tests++; if (bus.state !== 4'd0 || bus.illegal !== 1'b0) begin fails++; $display("FAIL ill_end got st=%0d ill=%0b want 0/0", bus.state, bus.illegal); end
    tick();
  endtask

  task automatic test_sw();
    bus.opcode = OP_SW; bus.mem_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    tests++; if (bus.state !== 4'd2 || bus.ALUSrcA !== 1'b1 || bus.ALUSrcB !== 2'b10) begin
      fails++; $display("FAIL sw_adr got st=%0d a=%0b b=%0b want 2/1/10", bus.state, bus.ALUSrcA, bus.ALUSrcB); end
    tick();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if (bus.state !== 4'd5 || bus.MemWrite !== 1'b0 || bus.instr_done !== 1'b0 || bus.mem_req !== 1'b1 || bus.IorD !== 1'b1) begin
        fails++; $display("FAIL sw_wait%0d got st=%0d mw=%0b done=%0b req=%0b iord=%0b want 5/0/0/1/1", i, bus.state, bus.MemWrite, bus.instr_done, bus.mem_req, bus.IorD); end
      tick();
    end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    tests++; if (bus.state !== 4'd5 || bus.MemWrite !== 1'b1 || bus.instr_done !== 1'b1) begin
      fails++; $display("FAIL sw_ready got st=%0d mw=%0b done=%0b want 5/1/1", bus.state, bus.MemWrite, bus.instr_done); end
    tick();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    tests++; if (bus.state !== 4'd0 || bus.MemWrite !== 1'b0) begin fails++; $display("FAIL sw_end got st=%0d mw=%0b want 0/0", bus.state, bus.MemWrite); end
    tick();
  endtask

  task automatic test_rtype_jump();
    bus.opcode = OP_R; bus.mem_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    tests++; if (bus.state !== 4'd6 || bus.ALUOp !== 2'b10 || bus.ALUSrcB !== 2'b00 || bus.ALUSrcA !== 1'b1) begin
      fails++; $display("FAIL r_ex got st=%0d op=%0b b=%0b a=%0b want 6/10/00/1", bus.state, bus.ALUOp, bus.ALUSrcB, bus.ALUSrcA); end
    tick();
    @(negedge clk);
    tests++; if (bus.state !== 4'd7 || bus.RegWrite !== 1'b1 || bus.RegDst !== 1'b1 || bus.instr_done !== 1'b1) begin
      fails++; $display("FAIL r_wb got st=%0d rw=%0b rd=%0b done=%0b want 7/1/1/1", bus.state, bus.RegWrite, bus.RegDst, bus.instr_done); end
    tick();
    bus.opcode = OP_J;
    tick();
    tick();
    @(negedge clk);
    tests++; if (bus.state !== 4'd11 || bus.PCSrc !== 2'b10 || bus.PCWrite !== 1'b1 || bus.instr_done !== 1'b1) begin
      fails++; $display("FAIL j_ex got st=%0d src=%0b pw=%0b done=%0b want 11/10/1/1", bus.state, bus.PCSrc, bus.PCWrite, bus.instr_done); end
    tick();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    tests++; if (bus.state !== 4'd0) begin fails++; $display("FAIL j_end got %0d want 0", bus.state); end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.opcode = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    #1;
    test_reset();
    test_lw();
    test_beq();
    test_imm();
    test_illegal();
    test_sw();
    test_rtype_jump();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle version of the MIPS core. Sequences fetch, decode, execute, memory and writeback over shared datapath resources: one ALU, one unified memory port, the immediate-extension unit. Decodes the 6-bit opcode, drives every datapath mux/enable per state, and selects the immediate-extension mode (sign, zero, upper). Stalls on a single memory-ready handshake.

## Interface
- No parameters; state encoding and opcodes are fixed below.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; state forced to FETCH at the next edge
- opcode  in  6  Instr[31:26] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access requested
- IorD  out  1  0 = PC address, 1 = ALUOut address
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- PCWrite  out  1  PC load, already combined with the branch condition
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 reg B, 01 constant 4, 10 extended immediate, 11 extended immediate << 2
- ALUOp  out  2  00 add, 01 subtract, 10 funct-decoded, 11 opcode-decoded logic (andi/ori/lui)
- ExtOp  out  2  00 sign-extend, 01 zero-extend, 10 upper (imm << 16), 11 reserved
- RegDst  out  1  0 = rt, 1 = rd
- MemtoReg  out  1  0 = ALUOut, 1 = memory data
- RegWrite  out  1  register-file write enable
- instr_done  out  1  one-cycle pulse on the last cycle of every instruction
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode
- state  out  4  current state, for debug

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, andi 001100, ori 001101, lui 001111, j 000010.
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, ALUWB=7, BEQEX=8, IMMEX=9, IMMWB=10, JEX=11. Codes 12-15 are unreachable and go to FETCH.
- FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite and PCWrite assert only when mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00, ExtOp=00 (branch target). Next state by opcode:
  - lw/sw → MEMADR
  - R → RTYPEEX
  - beq → BEQEX
  - addi/andi/ori/lui → IMMEX
  - j → JEX
  - any other opcode → FETCH, with illegal=1 and instr_done=1
- MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=00, ALUOp=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, IorD=1. Held until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1, instr_done=1. Goes to FETCH.
- MEMWR: mem_req=1, IorD=1, MemWrite=mem_ready.
  - Held until mem_ready.
  - instr_done=1 on the mem_ready cycle, then FETCH.
- RTYPEEX: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Goes to FETCH.
- BEQEX: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCWrite=zero, instr_done=1. Goes to FETCH.
- IMMEX: ALUSrcA=1, ALUSrcB=10. Goes to IMMWB.
  - addi: ExtOp=00, ALUOp=00.
  - andi/ori: ExtOp=01, ALUOp=11.
  - lui: ExtOp=10, ALUOp=11.
- IMMWB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. Keeps the same ExtOp as IMMEX. Goes to FETCH.
- JEX: PCSrc=10, PCWrite=1, instr_done=1. Goes to FETCH.
- Defaults: every output not listed for a state is 0; ExtOp defaults to 00.
- Only the state register holds state. Outputs are decoded combinationally from state, opcode, zero and mem_ready.
- opcode is sampled every cycle. Holding it stable from DECODE to the end of the instruction is the IR's job; IRWrite is low in those states.

## Timing
- Reset:
  - reset=1 at an edge → state=FETCH after that edge, regardless of current state or a pending mem_ready.
  - A memory cycle in flight is abandoned; no MemWrite, RegWrite or PCWrite is issued on the reset edge cycle.
  - While reset is high, outputs show FETCH decode: mem_req=1, IorD=0, ALUSrcB=01. PCWrite and IRWrite are forced to 0.
- Instruction cycle counts with mem_ready=1 on first request:
  - lw 5, sw 4, R 4, addi/andi/ori/lui 4, beq 3, j 3, illegal 2.
  - Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Writes to PC/IR/regfile/memory take effect at the clock edge ending the cycle in which their enable is high.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.

## Test plan
- Reset mid-MEMRD (state=3), reset=1 for 1 cycle → state=0 next cycle; RegWrite never asserted; mem_req=1.
- lw (opcode 100011), mem_ready held 0 for 2 cycles in FETCH and 1 cycle in MEMRD, otherwise 1 → state sequence 0,0,0,1,2,3,3,4,0; IRWrite=1 exactly once; instr_done on the MEMWB cycle only.
- beq with zero=1, then beq with zero=0 → PCWrite=1 with PCSrc=01 in the first BEQEX; PCWrite=0 in the second; both take 3 cycles.
- ori (001101), then lui (001111), then addi (001000) → ExtOp in IMMEX/IMMWB = 01, 10, 00 respectively; ALUOp = 11, 11, 00; RegWrite=1 with RegDst=0.
- Illegal opcode 111111 → illegal=1 and instr_done=1 in DECODE, then FETCH; no RegWrite, MemWrite or PCWrite in that instruction beyond the FETCH PC+4.
- sw (101011) with mem_ready=0 for 3 cycles in MEMWR → MemWrite=1 only on the single mem_ready cycle; instr_done on that same cycle; next state 0.
